two_to_four_pulse_decoder: RTL

Inverse of the team's 4:2 priority encoder. Accepts a 2-bit code with a valid/ready handshake (code mapping: 00→a, 01→b, 10→c, 11→d, i.e. out1 is the MSB and out0 the LSB, as the encoder produces them) and drives the matching one of four one-hot lines high for a fixed, programmable number of cycles. It also keeps a saturating event count per line. It sits downstream of the encoder, so that encoded request codes can be carried on 2 wires and re-expanded into line-level strobes.

---
 rtl/two_to_four_pulse_decoder_pkg.sv | 40 ++++
 rtl/two_to_four_pulse_decoder_sat_event_counter.sv | 27 ++
 rtl/two_to_four_pulse_decoder.sv | 104 ++++++++++
 3 files changed

// File: rtl/two_to_four_pulse_decoder_pkg.sv
// Shared definitions for the 2:4 pulse decoder and its 4:2 encoder counterpart.
//   - state encoding of the decoder FSM
//   - line codes as produced by the encoder ({out1,out0})
//   - helper functions for timer sizing and code-to-one-hot expansion
package two_to_four_pulse_decoder_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        DRIVE = ST_DRIVE
    } state_t;

    localparam logic [1:0] CODE_A = 2'b00;
    localparam logic [1:0] CODE_B = 2'b01;
    localparam logic [1:0] CODE_C = 2'b10;
    localparam logic [1:0] CODE_D = 2'b11;

    // Bits needed to hold PULSE_LEN-1; never narrower than one bit.
    function automatic int timer_w(input int pulse_len);
        int w;
        w = $clog2(pulse_len);
        return (w < 1) ? 1 : w;
    endfunction

    // Bit order of the result is {d, c, b, a}.
    function automatic logic [3:0] code_to_lines(input logic [1:0] code);
        logic [3:0] lines;
        lines = 4'b0000;
        case (code)
            CODE_A:  lines = 4'b0001;
            CODE_B:  lines = 4'b0010;
            CODE_C:  lines = 4'b0100;
            default: lines = 4'b1000;
        endcase
        return lines;
    endfunction

endpackage

// File: rtl/two_to_four_pulse_decoder_sat_event_counter.sv
// Saturating event counter, one per decoded line.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, zeroes the count
//   inc   : count one event this cycle
//   clr   : zero the count; an event in the same cycle leaves the count at 1
//   count : current count, sticks at all-ones
module sat_event_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/two_to_four_pulse_decoder.sv
// 2:4 pulse decoder. Takes a 2-bit line code over a valid/ready handshake and
// drives the matching one-hot line for PULSE_LEN cycles, counting accepts per
// line in saturating counters.
//   clk, reset         : clock, synchronous active-high reset
//   in_valid/in_code   : code offered by the source ({out1,out0})
//   in_ready           : a code can be taken this cycle
//   a, b, c, d         : registered decoded lines for codes 00..11
//   busy               : any decoded line is high
//   cnt_sel/cnt_out    : read-out of one of the four event counters
//   cnt_clear          : zero all event counters
//
// state | meaning
// IDLE  | no line driven, ready for a code
// DRIVE | one line high; timer counts the remaining cycles down to 0
module two_to_four_pulse_decoder
    import two_to_four_pulse_decoder_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       in_code,
    output logic             in_ready,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    input  logic [1:0]       cnt_sel,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] cnt_out
);

    localparam int            TW         = timer_w(PULSE_LEN);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(PULSE_LEN - 1);

    state_t          state;
    logic [TW-1:0]   timer;
    logic [3:0]      lines;
    logic            accept;
    logic [CNT_W-1:0] counts [4];

    // Ready on the last pulse cycle too, so a new code follows with no gap.
    assign in_ready = !reset && ((state == IDLE) || (timer == '0));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            lines <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= DRIVE;
                        timer <= TIMER_LOAD;
                        lines <= code_to_lines(in_code);
                    end
                end
                default: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (accept) begin
                        timer <= TIMER_LOAD;
                        lines <= code_to_lines(in_code);
                    end else begin
                        state <= IDLE;
                        lines <= 4'b0000;
                    end
                end
            endcase
        end
    end

    assign a    = lines[0];
    assign b    = lines[1];
    assign c    = lines[2];
    assign d    = lines[3];
    assign busy = |lines;

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        sat_event_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (accept && (in_code == 2'(i))),
            .clr   (cnt_clear),
            .count (counts[i])
        );
    end

    always_comb begin
        cnt_out = counts[0];
        case (cnt_sel)
            CODE_A:  cnt_out = counts[0];
            CODE_B:  cnt_out = counts[1];
            CODE_C:  cnt_out = counts[2];
            default: cnt_out = counts[3];
        endcase
    end

endmodule
